spi1_cmd_target: RTL and testbench

- FPGA-side SPI target for the MCU's SPI1 command channel.
- Deserialises MCU commands (write_at, read_at, read_next, write_next) and issues single-byte transactions on the internal 17-bit RAM/bus arbiter port.
- Returns read data on the following command.
- Holds spi_stall_o high while a bus transaction is pending.

---
 rtl/spi1_cmd_target.sv | 133 +++++++++++++
 tb/tb_spi1_cmd_target.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/spi1_cmd_target.sv
// spi1_cmd_target: SPI1 mode-0 command target issuing byte transactions on the RAM/bus arbiter port.
// Define SPI1_BAD_CMD_FLAG_EN to build the sticky protocol-error flag bad_cmd_o.
module spi1_cmd_target #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 17,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  spi1_cs_ni,
  input  logic                  spi1_sck_i,
  input  logic                  spi1_sd_i,
  output logic                  spi1_sd_o,
  output logic                  spi_stall_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [DATA_WIDTH-1:0] bus_data_o,
  input  logic [DATA_WIDTH-1:0] bus_data_i,
  output logic                  bus_we_o,
  output logic                  bus_req_o,
  input  logic                  bus_ack_i,
  output logic                  bad_cmd_o
);
  typedef enum logic [2:0] {IDLE, CMD, DATA, ADDR_HI, ADDR_LO, BUS, DISCARD} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, sd_sync;
  logic cs_prev, sck_prev, cs_s, sck_s, sd_s;
  logic cs_fall, cs_rise, sck_rise, sck_fall, byte_done, rd_load, at_cmd;
  logic [2:0] bit_cnt;
  logic [DATA_WIDTH-2:0] rx_sr;
  logic [DATA_WIDTH-1:0] rx_byte, tx_sr, rd_data;
  logic [ADDR_WIDTH-9:0] addr_hi;
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sck_s     = sck_sync[SYNC_STAGES-1];
  assign sd_s      = sd_sync[SYNC_STAGES-1];
  assign cs_fall   = cs_prev & ~cs_s;
  assign cs_rise   = ~cs_prev & cs_s;
  assign sck_rise  = ~cs_s & ~sck_prev & sck_s;
  assign sck_fall  = ~cs_s & sck_prev & ~sck_s;
  assign byte_done = sck_rise && bit_cnt == 3'd7;
  assign rx_byte   = {rx_sr, sd_s};
  assign rd_load   = bus_req_o & bus_ack_i & ~bus_we_o;
  assign spi1_sd_o = tx_sr[DATA_WIDTH-1];
  // The fall right after a byte boundary keeps the freshly loaded MSB on POCI.
  always_ff @(posedge clock_i)
    if (reset_i) begin
      cs_sync  <= {SYNC_STAGES{1'b1}};
      sck_sync <= '0;
      sd_sync  <= '0;
      cs_prev  <= 1'b1;
      sck_prev <= 1'b0;
      bit_cnt  <= 3'd0;
      rx_sr    <= '0;
      tx_sr    <= '0;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], spi1_cs_ni};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi1_sck_i};
      sd_sync  <= {sd_sync[SYNC_STAGES-2:0], spi1_sd_i};
      cs_prev  <= cs_s;
      sck_prev <= sck_s;
      if (cs_fall) begin
        bit_cnt <= 3'd0;
        tx_sr   <= rd_data;
      end else if (sck_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        rx_sr   <= rx_byte[DATA_WIDTH-2:0];
        if (bit_cnt == 3'd7) tx_sr <= rd_data;
      end else if (sck_fall && bit_cnt != 3'd0) tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
      else if (rd_load && bit_cnt == 3'd0) tx_sr <= bus_data_i;
    end
  always_ff @(posedge clock_i)
    if (reset_i) begin
      state       <= IDLE;
      bus_req_o   <= 1'b0;
      spi_stall_o <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_data_o  <= '0;
      rd_data     <= '0;
      addr_hi     <= '0;
      at_cmd      <= 1'b0;
    end else if (state == BUS) begin
      if (bus_ack_i) begin
        bus_req_o   <= 1'b0;
        spi_stall_o <= 1'b0;
        bus_addr_o  <= bus_addr_o + 1'b1;
        if (!bus_we_o) rd_data <= bus_data_i;
        state <= IDLE;
      end
    end else if (cs_rise) state <= IDLE;
    else if (cs_fall) state <= CMD;
    else if (byte_done) begin
      case (state)
        IDLE, CMD: begin
          addr_hi[ADDR_WIDTH-9] <= rx_byte[0];
          at_cmd <= ~rx_byte[5];
          if (!rx_byte[7]) bus_we_o <= rx_byte[6];
          state <= rx_byte[7] ? DISCARD : rx_byte[6] ? DATA : rx_byte[5] ? BUS : ADDR_HI;
          if (rx_byte[7:5] == 3'b001) begin
            bus_req_o   <= 1'b1;
            spi_stall_o <= 1'b1;
          end
        end
        DATA: begin
          bus_data_o <= rx_byte;
          state <= at_cmd ? ADDR_HI : BUS;
          if (!at_cmd) begin
            bus_req_o   <= 1'b1;
            spi_stall_o <= 1'b1;
          end
        end
        ADDR_HI: begin
          addr_hi[7:0] <= rx_byte;
          state <= ADDR_LO;
        end
        ADDR_LO: begin
          bus_addr_o  <= {addr_hi, rx_byte};
          bus_req_o   <= 1'b1;
          spi_stall_o <= 1'b1;
          state <= BUS;
        end
        default: ;
      endcase
    end
`ifdef SPI1_BAD_CMD_FLAG_EN
  always_ff @(posedge clock_i)
    if (reset_i) bad_cmd_o <= 1'b0;
    else if ((byte_done && (state == BUS || ((state == IDLE || state == CMD) && rx_byte[7])))
             || (cs_rise && (state == DATA || state == ADDR_HI || state == ADDR_LO)))
      bad_cmd_o <= 1'b1;
`else
  assign bad_cmd_o = 1'b0;
`endif
endmodule

// File: tb/tb_spi1_cmd_target.sv
// tb_spi1_cmd_target: directed and random SPI1 commands against a mock RAM and a command-level model.
module tb_spi1_cmd_target;
  localparam int SYNC = 2;
`ifdef SPI1_BAD_CMD_FLAG_EN
  localparam bit BAD_EN = 1'b1;
`else
  localparam bit BAD_EN = 1'b0;
`endif
  logic clk = 1'b0, reset_i = 1'b1, cs = 1'b1, sck = 1'b0, sd = 1'b0;
  logic spi1_sd_o, spi_stall_o, bus_we_o, bus_req_o, bus_ack, bad_cmd_o;
  logic resp_ack = 1'b0, tb_ack = 1'b0, hold_ack = 1'b0;
  logic [16:0] bus_addr_o;
  logic [7:0] bus_data_o, bus_rdata = 8'h00;
  int n_checks = 0, n_fail = 0, ack_delay = 3;
  logic [7:0] ram [0:131071];
  logic [7:0] model_mem [0:131071];
  logic [16:0] ptr = '0;
  logic [7:0] rd_val = '0;
  logic [16:0] q_addr[$];
  logic [7:0] q_data[$];
  logic q_we[$], q_stable[$], q_stall[$];
  assign bus_ack = resp_ack | tb_ack;
  always #5 clk = ~clk;
  spi1_cmd_target dut (
    .clock_i(clk), .reset_i(reset_i), .spi1_cs_ni(cs), .spi1_sck_i(sck), .spi1_sd_i(sd),
    .spi1_sd_o(spi1_sd_o), .spi_stall_o(spi_stall_o), .bus_addr_o(bus_addr_o),
    .bus_data_o(bus_data_o), .bus_data_i(bus_rdata), .bus_we_o(bus_we_o),
    .bus_req_o(bus_req_o), .bus_ack_i(bus_ack), .bad_cmd_o(bad_cmd_o)
  );
  // Mock arbiter: acks ack_delay cycles after a request appears and logs what it saw.
  initial begin
    logic prev_req, s_we;
    logic [16:0] s_addr;
    logic [7:0] s_data;
    int wcnt;
    prev_req = 1'b0;
    wcnt = 0;
    s_we = 1'b0;
    s_addr = '0;
    s_data = '0;
    forever begin
      @(negedge clk);
      resp_ack = 1'b0;
      if (bus_req_o && !hold_ack) begin
        if (!prev_req) begin
          wcnt = ack_delay;
          s_addr = bus_addr_o;
          s_we = bus_we_o;
          s_data = bus_data_o;
        end
        if (wcnt == 0) begin
          resp_ack = 1'b1;
          q_addr.push_back(bus_addr_o);
          q_we.push_back(bus_we_o);
          q_data.push_back(bus_data_o);
          q_stable.push_back(bus_addr_o == s_addr && bus_we_o == s_we && bus_data_o == s_data);
          q_stall.push_back(spi_stall_o);
          if (bus_we_o) ram[bus_addr_o] = bus_data_o;
          else bus_rdata = ram[bus_addr_o];
        end else wcnt--;
      end
      prev_req = bus_req_o && !hold_ack;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx, output int lat);
    rx = '0;
    lat = 99;
    for (int i = 7; i >= 0; i--) begin
      sd = tx[i];
      wait_clk(5);
      rx = {rx[6:0], spi1_sd_o};
      sck = 1'b1;
      for (int k = 1; k <= 5; k++) begin
        @(negedge clk);
        if (i == 0 && spi_stall_o && lat == 99) lat = k;
      end
      sck = 1'b0;
    end
  endtask
  task automatic do_cmd(input string tag, input logic [2:0] op, input logic [16:0] a, input logic [7:0] d);
    logic [7:0] b[$];
    logic [7:0] rx;
    logic [16:0] ea;
    int lat;
    b.push_back({op, 4'b0000, a[16]});
    if (op == 3'd2 || op == 3'd3) b.push_back(d);
    if (op == 3'd0 || op == 3'd2) begin
      b.push_back(a[15:8]);
      b.push_back(a[7:0]);
    end
    if (op[2]) begin
      b.push_back(8'hA5);
      b.push_back(8'h3C);
    end
    cs = 1'b0;
    wait_clk(5);
    lat = 99;
    foreach (b[i]) begin
      spi_byte(b[i], rx, lat);
      if (i == 0) chk({tag, "_poci"}, rx, rd_val);
    end
    if (!op[2]) chk({tag, "_stall_lat_ok"}, lat >= 1 && lat <= SYNC + 3, 1);
    for (int k = 0; k < 80 && spi_stall_o; k++) @(negedge clk);
    chk({tag, "_stall_drop"}, spi_stall_o, 0);
    wait_clk(2);
    cs = 1'b1;
    wait_clk(4);
    chk({tag, "_nreq"}, q_addr.size(), op[2] ? 0 : 1);
    if (!op[2] && q_addr.size() > 0) begin
      ea = (op == 3'd0 || op == 3'd2) ? a : ptr;
      chk({tag, "_addr"}, q_addr.pop_front(), ea);
      chk({tag, "_we"}, q_we.pop_front(), op[1]);
      chk({tag, "_stable"}, q_stable.pop_front(), 1);
      chk({tag, "_stall_at_ack"}, q_stall.pop_front(), 1);
      if (op[1]) begin
        chk({tag, "_wdata"}, q_data.pop_front(), d);
        model_mem[ea] = d;
      end else begin
        void'(q_data.pop_front());
        rd_val = model_mem[ea];
      end
      ptr = ea + 17'd1;
    end
  endtask
  initial begin
    logic [7:0] rx;
    int lat;
    for (int i = 0; i < 131072; i++) begin
      ram[i] = 8'($urandom);
      model_mem[i] = ram[i];
    end
    ram[0] = 8'h01; model_mem[0] = 8'h01;
    ram[1] = 8'h02; model_mem[1] = 8'h02;
    wait_clk(3);
    reset_i = 1'b0;
    wait_clk(1);
    chk("rst_sd", spi1_sd_o, 0);
    chk("rst_stall", spi_stall_o, 0);
    chk("rst_req", bus_req_o, 0);
    chk("rst_we", bus_we_o, 0);
    chk("rst_addr", bus_addr_o, 0);
    chk("rst_data", bus_data_o, 0);
    chk("rst_bad", bad_cmd_o, 0);
    do_cmd("wr_at", 3'd2, 17'h01234, 8'h5A);
    ack_delay = 1;
    do_cmd("rd_at0", 3'd0, 17'h00000, 8'h00);
    do_cmd("rd_nx1", 3'd1, 17'h00000, 8'h00);
    do_cmd("rd_nx2", 3'd1, 17'h00000, 8'h00);
    do_cmd("rd_nx3", 3'd1, 17'h00000, 8'h00);
    ack_delay = 0;
    do_cmd("wr_top", 3'd2, 17'h1FFFF, 8'h77);
    do_cmd("wr_wrap", 3'd3, 17'h00000, 8'h88);
    do_cmd("rd_top", 3'd0, 17'h1FFFF, 8'h00);
    do_cmd("rd_top_nx", 3'd1, 17'h00000, 8'h00);
    do_cmd("rd_wrap_nx", 3'd1, 17'h00000, 8'h00);
    ack_delay = 2;
    cs = 1'b0;
    wait_clk(5);
    spi_byte(8'h40, rx, lat);
    spi_byte(8'hC3, rx, lat);
    cs = 1'b1;
    wait_clk(10);
    chk("abort_nreq", q_addr.size(), 0);
    chk("abort_req", bus_req_o, 0);
    chk("abort_bad", bad_cmd_o, BAD_EN);
    do_cmd("rd_at10", 3'd0, 17'h00010, 8'h00);
    do_cmd("rd_at10_nx", 3'd1, 17'h00000, 8'h00);
    hold_ack = 1'b1;
    cs = 1'b0;
    wait_clk(5);
    spi_byte(8'h20, rx, lat);
    for (int k = 0; k < 20 && !bus_req_o; k++) @(negedge clk);
    chk("hold_req", bus_req_o, 1);
    cs = 1'b1;
    reset_i = 1'b1;
    wait_clk(1);
    reset_i = 1'b0;
    chk("mid_rst_req", bus_req_o, 0);
    chk("mid_rst_stall", spi_stall_o, 0);
    chk("mid_rst_sd", spi1_sd_o, 0);
    chk("mid_rst_bad", bad_cmd_o, 0);
    tb_ack = 1'b1;
    wait_clk(1);
    tb_ack = 1'b0;
    wait_clk(2);
    chk("late_ack_req", bus_req_o, 0);
    chk("late_ack_addr", bus_addr_o, 0);
    hold_ack = 1'b0;
    ptr = '0;
    rd_val = '0;
    do_cmd("bad_e0", 3'd7, 17'h00000, 8'h00);
    chk("bad_set", bad_cmd_o, BAD_EN);
    do_cmd("post_bad_rd", 3'd1, 17'h00000, 8'h00);
    chk("bad_sticky", bad_cmd_o, BAD_EN);
    for (int n = 0; n < 24; n++) begin
      logic [16:0] ra;
      ack_delay = $urandom_range(0, 4);
      ra = ($urandom_range(0, 3) == 0) ? 17'h1FFFF : 17'($urandom_range(0, 131071));
      do_cmd("rand", 3'($urandom_range(0, 3)), ra, 8'($urandom));
    end
    chk("bad_final", bad_cmd_o, BAD_EN);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
